ysyx_22040895_ifu: RTL and testbench

Instruction fetch unit directly downstream of the PC register. Accepts the current fetch PC and chip-enable and issues one read to instruction memory over a req/gnt/rvalid handshake. Selects the 32-bit instruction from the 64-bit beat and presents it to decode over a valid/ready handshake. Back-pressures the PC stage, handles redirect flushes with one outstanding request, and flags misaligned PCs.

---
 rtl/ysyx_22040895_ifu.sv | 119 +++++++++++
 tb/tb_ysyx_22040895_ifu.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/ysyx_22040895_ifu.sv
// ysyx_22040895_ifu: instruction fetch unit, one outstanding imem read, valid/ready to decode.
// Optional 64-bit performance counters enabled by defining YSYX_22040895_IFU_PERF_EN.
module ysyx_22040895_ifu #(
  parameter int          ADDR_W     = 64,
  parameter logic [31:0] RESET_INST = 32'h00000013
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              ce_i,
  output logic              pc_ready_o,
  input  logic              flush_i,
  output logic              imem_req_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic              imem_gnt_i,
  input  logic              imem_rvalid_i,
  input  logic [63:0]       imem_rdata_i,
  output logic              inst_valid_o,
  input  logic              inst_ready_i,
  output logic [31:0]       inst_o,
  output logic [ADDR_W-1:0] inst_pc_o,
  output logic              inst_misalign_o
`ifdef YSYX_22040895_IFU_PERF_EN
  ,
  output logic [63:0]       perf_fetch_cnt_o,
  output logic [63:0]       perf_stall_cnt_o
`endif
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_e;
  state_e            state_q, state_d;
  logic              drop_q, drop_d;
  logic              mis_q, mis_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] inst_pc_q, inst_pc_d;
  logic [31:0]       inst_q, inst_d;
  logic              hs;
  assign hs           = state_q == HOLD && inst_ready_i && !flush_i;
  assign pc_ready_o   = !rst && !flush_i && ce_i && (state_q == IDLE || hs);
  assign imem_req_o   = state_q == REQ;
  assign imem_addr_o  = imem_req_o ? {pc_q[ADDR_W-1:3], 3'b000} : '0;
  assign inst_valid_o = state_q == HOLD;
  assign inst_o       = inst_valid_o && !mis_q ? inst_q : RESET_INST;
  assign inst_pc_o    = inst_pc_q;
  assign inst_misalign_o = inst_valid_o && mis_q;
  always_comb begin
    state_d   = state_q;
    drop_d    = drop_q;
    mis_d     = mis_q;
    pc_d      = pc_ready_o ? pc_i : pc_q;
    inst_pc_d = inst_pc_q;
    inst_d    = inst_q;
    case (state_q)
      IDLE, HOLD: begin
        if (flush_i) begin
          state_d = IDLE;
        end else if (pc_ready_o) begin
          state_d = |pc_i[1:0] ? HOLD : REQ;
          mis_d   = |pc_i[1:0];
          inst_pc_d = |pc_i[1:0] ? pc_i : inst_pc_q;
        end else if (hs) begin
          state_d = IDLE;
        end
      end
      REQ: begin
        drop_d  = drop_q || flush_i;
        state_d = imem_gnt_i ? WAIT : REQ;
      end
      default: begin
        // A flush arriving with the response still kills that response.
        if (imem_rvalid_i) begin
          drop_d = 1'b0;
          if (drop_q || flush_i) begin
            state_d = IDLE;
          end else begin
            state_d   = HOLD;
            mis_d     = 1'b0;
            inst_d    = pc_q[2] ? imem_rdata_i[63:32] : imem_rdata_i[31:0];
            inst_pc_d = pc_q;
          end
        end else begin
          drop_d = drop_q || flush_i;
        end
      end
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      drop_q    <= 1'b0;
      mis_q     <= 1'b0;
      pc_q      <= '0;
      inst_pc_q <= '0;
      inst_q    <= RESET_INST;
    end else begin
      state_q   <= state_d;
      drop_q    <= drop_d;
      mis_q     <= mis_d;
      pc_q      <= pc_d;
      inst_pc_q <= inst_pc_d;
      inst_q    <= inst_d;
    end
  end
`ifdef YSYX_22040895_IFU_PERF_EN
  logic [63:0] fetch_q, fetch_d, stall_q, stall_d;
  assign fetch_d = fetch_q + {63'd0, hs};
  assign stall_d = stall_q + {63'd0, state_q == REQ || state_q == WAIT};
  assign perf_fetch_cnt_o = fetch_q;
  assign perf_stall_cnt_o = stall_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_q <= '0;
      stall_q <= '0;
    end else begin
      fetch_q <= fetch_d;
      stall_q <= stall_d;
    end
  end
`endif
endmodule

// File: tb/tb_ysyx_22040895_ifu.sv
// tb_ysyx_22040895_ifu: directed self-checking bench for the fetch unit.
module tb_ysyx_22040895_ifu;
  logic        clk = 0, rst = 1, ce_i = 0, flush_i = 0, imem_gnt_i = 0, imem_rvalid_i = 0, inst_ready_i = 0;
  logic [63:0] pc_i = 0, imem_rdata_i = 0, imem_addr_o, inst_pc_o;
  logic        pc_ready_o, imem_req_o, inst_valid_o, inst_misalign_o;
  logic [31:0] inst_o;
  int          n_cmp = 0, n_err = 0;
  localparam logic [31:0] NOP = 32'h00000013;
`ifdef YSYX_22040895_IFU_PERF_EN
  logic [63:0] perf_fetch_cnt_o, perf_stall_cnt_o, stall_base;
`endif
  ysyx_22040895_ifu dut (
    .clk(clk), .rst(rst), .pc_i(pc_i), .ce_i(ce_i), .pc_ready_o(pc_ready_o), .flush_i(flush_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i), .inst_valid_o(inst_valid_o),
    .inst_ready_i(inst_ready_i), .inst_o(inst_o), .inst_pc_o(inst_pc_o), .inst_misalign_o(inst_misalign_o)
`ifdef YSYX_22040895_IFU_PERF_EN
    , .perf_fetch_cnt_o(perf_fetch_cnt_o), .perf_stall_cnt_o(perf_stall_cnt_o)
`endif
  );
  always #5 clk = ~clk;

  task automatic test_reset();
    pc_i = 64'h80000010; ce_i = 1; @(negedge clk);
    ce_i = 0; imem_gnt_i = 1; @(negedge clk);
    imem_gnt_i = 0; ce_i = 1; #2 rst = 1; #1;
    n_cmp++; if (pc_ready_o !== 1'b0) begin n_err++; $display("FAIL rst_pc_ready: got %b want 0", pc_ready_o); end
    n_cmp++; if (imem_req_o !== 1'b0) begin n_err++; $display("FAIL rst_req: got %b want 0", imem_req_o); end
    n_cmp++; if (imem_addr_o !== 64'h0) begin n_err++; $display("FAIL rst_addr: got %h want 0", imem_addr_o); end
    n_cmp++; if (inst_valid_o !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", inst_valid_o); end
    n_cmp++; if (inst_o !== NOP) begin n_err++; $display("FAIL rst_inst: got %h want %h", inst_o, NOP); end
    n_cmp++; if (inst_pc_o !== 64'h0) begin n_err++; $display("FAIL rst_inst_pc: got %h want 0", inst_pc_o); end
    n_cmp++; if (inst_misalign_o !== 1'b0) begin n_err++; $display("FAIL rst_misalign: got %b want 0", inst_misalign_o); end
    @(negedge clk); rst = 0; pc_i = 64'h80000000; #1;
    n_cmp++; if (pc_ready_o !== 1'b1) begin n_err++; $display("FAIL rst_cap_ready: got %b want 1", pc_ready_o); end
    @(negedge clk); ce_i = 0;
    n_cmp++; if (imem_req_o !== 1'b1 || imem_addr_o !== 64'h80000000) begin n_err++; $display("FAIL rst_cap_addr: got req=%b addr=%h want req=1 addr=80000000", imem_req_o, imem_addr_o); end
    imem_gnt_i = 1; @(negedge clk);
    imem_gnt_i = 0; imem_rvalid_i = 1; imem_rdata_i = 64'h00000000_00100073; @(negedge clk);
    imem_rvalid_i = 0;
    n_cmp++; if (inst_o !== 32'h00100073) begin n_err++; $display("FAIL rst_cap_inst: got %h want 00100073", inst_o); end
    inst_ready_i = 1; @(negedge clk); inst_ready_i = 0;
  endtask

  task automatic test_fetch();
    pc_i = 64'h80000004; ce_i = 1; #1;
    n_cmp++; if (pc_ready_o !== 1'b1) begin n_err++; $display("FAIL fetch_ready: got %b want 1", pc_ready_o); end
    @(negedge clk); ce_i = 0;
    n_cmp++; if (imem_req_o !== 1'b1 || imem_addr_o !== 64'h80000000 || inst_valid_o !== 1'b0) begin n_err++; $display("FAIL fetch_req: got req=%b addr=%h valid=%b want 1/80000000/0", imem_req_o, imem_addr_o, inst_valid_o); end
    imem_gnt_i = 1; @(negedge clk); imem_gnt_i = 0;
    n_cmp++; if (imem_req_o !== 1'b0 || inst_valid_o !== 1'b0) begin n_err++; $display("FAIL fetch_wait: got req=%b valid=%b want 0/0", imem_req_o, inst_valid_o); end
    imem_rvalid_i = 1; imem_rdata_i = 64'h00500093_00000013; @(negedge clk); imem_rvalid_i = 0;
    n_cmp++; if (inst_valid_o !== 1'b1 || inst_o !== 32'h00500093 || inst_pc_o !== 64'h80000004 || inst_misalign_o !== 1'b0) begin n_err++; $display("FAIL fetch_inst: got v=%b inst=%h pc=%h mis=%b want 1/00500093/80000004/0", inst_valid_o, inst_o, inst_pc_o, inst_misalign_o); end
  endtask

  task automatic test_stall();
    pc_i = 64'h80000008; ce_i = 1; inst_ready_i = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_cmp++; if (pc_ready_o !== 1'b0 || inst_valid_o !== 1'b1 || inst_o !== 32'h00500093 || inst_pc_o !== 64'h80000004) begin n_err++; $display("FAIL stall_hold%0d: got rdy=%b v=%b inst=%h pc=%h want 0/1/00500093/80000004", i, pc_ready_o, inst_valid_o, inst_o, inst_pc_o); end
      @(negedge clk);
    end
    inst_ready_i = 1; #1;
    n_cmp++; if (pc_ready_o !== 1'b1) begin n_err++; $display("FAIL stall_release_ready: got %b want 1", pc_ready_o); end
    @(negedge clk); inst_ready_i = 0; ce_i = 0;
    n_cmp++; if (imem_req_o !== 1'b1 || imem_addr_o !== 64'h80000008 || inst_valid_o !== 1'b0) begin n_err++; $display("FAIL b2b_req: got req=%b addr=%h valid=%b want 1/80000008/0", imem_req_o, imem_addr_o, inst_valid_o); end
    imem_gnt_i = 1; @(negedge clk);
    imem_gnt_i = 0; imem_rvalid_i = 1; imem_rdata_i = 64'h12345678_00208193; @(negedge clk); imem_rvalid_i = 0;
    n_cmp++; if (inst_o !== 32'h00208193 || inst_pc_o !== 64'h80000008) begin n_err++; $display("FAIL b2b_inst: got inst=%h pc=%h want 00208193/80000008", inst_o, inst_pc_o); end
    inst_ready_i = 1; @(negedge clk); inst_ready_i = 0;
    n_cmp++; if (inst_valid_o !== 1'b0 || inst_o !== NOP) begin n_err++; $display("FAIL b2b_idle: got v=%b inst=%h want 0/%h", inst_valid_o, inst_o, NOP); end
  endtask

  task automatic test_flush_wait();
    pc_i = 64'h800000F0; ce_i = 1; @(negedge clk); ce_i = 0;
    imem_gnt_i = 1; @(negedge clk); imem_gnt_i = 0;
    flush_i = 1; ce_i = 1; pc_i = 64'h80000100; #1;
    n_cmp++; if (pc_ready_o !== 1'b0) begin n_err++; $display("FAIL fw_ready_flush: got %b want 0", pc_ready_o); end
    @(negedge clk); flush_i = 0; #1;
    n_cmp++; if (pc_ready_o !== 1'b0 || inst_valid_o !== 1'b0) begin n_err++; $display("FAIL fw_wait: got rdy=%b v=%b want 0/0", pc_ready_o, inst_valid_o); end
    @(negedge clk); imem_rvalid_i = 1; imem_rdata_i = 64'hDEADBEEF_DEADBEEF; #1;
    n_cmp++; if (pc_ready_o !== 1'b0) begin n_err++; $display("FAIL fw_rvalid_ready: got %b want 0", pc_ready_o); end
    @(negedge clk); imem_rvalid_i = 0; #1;
    n_cmp++; if (inst_valid_o !== 1'b0 || inst_o !== NOP || pc_ready_o !== 1'b1) begin n_err++; $display("FAIL fw_discard: got v=%b inst=%h rdy=%b want 0/%h/1", inst_valid_o, inst_o, pc_ready_o, NOP); end
    @(negedge clk); ce_i = 0;
    n_cmp++; if (imem_req_o !== 1'b1 || imem_addr_o !== 64'h80000100) begin n_err++; $display("FAIL fw_refetch_req: got req=%b addr=%h want 1/80000100", imem_req_o, imem_addr_o); end
    imem_gnt_i = 1; @(negedge clk);
    imem_gnt_i = 0; imem_rvalid_i = 1; imem_rdata_i = 64'hCAFEF00D_00C00513; @(negedge clk); imem_rvalid_i = 0;
    n_cmp++; if (inst_valid_o !== 1'b1 || inst_o !== 32'h00C00513 || inst_pc_o !== 64'h80000100) begin n_err++; $display("FAIL fw_refetch_inst: got v=%b inst=%h pc=%h want 1/00c00513/80000100", inst_valid_o, inst_o, inst_pc_o); end
    inst_ready_i = 1; @(negedge clk); inst_ready_i = 0;
  endtask

  task automatic test_flush_req();
    pc_i = 64'h80000184; ce_i = 1; @(negedge clk); ce_i = 0;
    flush_i = 1; @(negedge clk); flush_i = 0;
    n_cmp++; if (imem_req_o !== 1'b1 || imem_addr_o !== 64'h80000180) begin n_err++; $display("FAIL fr_req_held: got req=%b addr=%h want 1/80000180", imem_req_o, imem_addr_o); end
    imem_gnt_i = 1; @(negedge clk); imem_gnt_i = 0;
    imem_rvalid_i = 1; imem_rdata_i = 64'h00000001_00000001; @(negedge clk); imem_rvalid_i = 0;
    ce_i = 1; pc_i = 64'h80000300; #1;
    n_cmp++; if (inst_valid_o !== 1'b0 || imem_req_o !== 1'b0 || pc_ready_o !== 1'b1) begin n_err++; $display("FAIL fr_discard: got v=%b req=%b rdy=%b want 0/0/1", inst_valid_o, imem_req_o, pc_ready_o); end
    ce_i = 0;
  endtask

  task automatic test_misalign();
    pc_i = 64'h80000002; ce_i = 1; @(negedge clk); ce_i = 0;
    n_cmp++; if (imem_req_o !== 1'b0 || inst_valid_o !== 1'b1 || inst_misalign_o !== 1'b1 || inst_o !== NOP || inst_pc_o !== 64'h80000002) begin n_err++; $display("FAIL mis_hold: got req=%b v=%b mis=%b inst=%h pc=%h want 0/1/1/%h/80000002", imem_req_o, inst_valid_o, inst_misalign_o, inst_o, inst_pc_o, NOP); end
    inst_ready_i = 1; @(negedge clk); inst_ready_i = 0;
    n_cmp++; if (inst_valid_o !== 1'b0 || inst_misalign_o !== 1'b0 || imem_req_o !== 1'b0) begin n_err++; $display("FAIL mis_done: got v=%b mis=%b req=%b want 0/0/0", inst_valid_o, inst_misalign_o, imem_req_o); end
  endtask

  task automatic test_flush_hold();
    pc_i = 64'h80000200; ce_i = 1; @(negedge clk); ce_i = 0;
`ifdef YSYX_22040895_IFU_PERF_EN
    stall_base = perf_stall_cnt_o;
`endif
    for (int i = 0; i < 2; i++) begin
      n_cmp++; if (imem_req_o !== 1'b1 || imem_addr_o !== 64'h80000200) begin n_err++; $display("FAIL fh_req_stable%0d: got req=%b addr=%h want 1/80000200", i, imem_req_o, imem_addr_o); end
      @(negedge clk);
    end
    imem_gnt_i = 1; @(negedge clk);
    imem_gnt_i = 0; imem_rvalid_i = 1; imem_rdata_i = 64'h11111111_00A00593; @(negedge clk); imem_rvalid_i = 0;
    n_cmp++; if (inst_valid_o !== 1'b1 || inst_o !== 32'h00A00593) begin n_err++; $display("FAIL fh_inst: got v=%b inst=%h want 1/00a00593", inst_valid_o, inst_o); end
`ifdef YSYX_22040895_IFU_PERF_EN
    n_cmp++; if (perf_fetch_cnt_o !== 64'd5) begin n_err++; $display("FAIL perf_fetch_pre: got %0d want 5", perf_fetch_cnt_o); end
    n_cmp++; if (perf_stall_cnt_o - stall_base !== 64'd4) begin n_err++; $display("FAIL perf_stall_delta: got %0d want 4", perf_stall_cnt_o - stall_base); end
`endif
    inst_ready_i = 1; ce_i = 1; pc_i = 64'h80000204; flush_i = 1; #1;
    n_cmp++; if (pc_ready_o !== 1'b0) begin n_err++; $display("FAIL fh_ready: got %b want 0", pc_ready_o); end
    @(negedge clk); flush_i = 0; inst_ready_i = 0; ce_i = 0;
    n_cmp++; if (inst_valid_o !== 1'b0 || imem_req_o !== 1'b0 || inst_o !== NOP) begin n_err++; $display("FAIL fh_killed: got v=%b req=%b inst=%h want 0/0/%h", inst_valid_o, imem_req_o, inst_o, NOP); end
`ifdef YSYX_22040895_IFU_PERF_EN
    n_cmp++; if (perf_fetch_cnt_o !== 64'd5) begin n_err++; $display("FAIL perf_fetch_post: got %0d want 5", perf_fetch_cnt_o); end
`endif
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 0;
    test_reset();
    test_fetch();
    test_stall();
    test_flush_wait();
    test_flush_req();
    test_misalign();
    test_flush_hold();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
